// File: rtl/mem_stack_ctrl.sv
// mem_stack_ctrl
//   Word-addressed memory with a downward-growing stack and a test-load port.
//   One request is accepted per access from IDLE, held for WAIT_CYC wait
//   cycles, then completed in DONE with a one-cycle done pulse.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_rd / req_wr / req_rd_ab  single read, write, double read at addr
//   req_push / req_pop           stack push of wdata / pop into rdata
//   addr, wdata                  access address and write/push data
//   test_en, test_ad, test_dat   test-load strobe, address and data
//   rdata, rdata_ab              read/pop result, {mem[addr], mem[addr+1]}
//   sp                           stack pointer (STACK_TOP when empty)
//   busy, done, err              access in progress, completion, error status
module mem_stack_ctrl #(
   parameter int DW          = 8,
   parameter int AW          = 16,
   parameter int DEPTH       = 256,
   parameter int STACK_TOP   = 256,
   parameter int STACK_LIMIT = 192,
   parameter int WAIT_CYC    = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_rd,
   input  logic            req_wr,
   input  logic            req_rd_ab,
   input  logic            req_push,
   input  logic            req_pop,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wdata,
   input  logic            test_en,
   input  logic [AW-1:0]   test_ad,
   input  logic [DW-1:0]   test_dat,
   output logic [DW-1:0]   rdata,
   output logic [2*DW-1:0] rdata_ab,
   output logic [AW-1:0]   sp,
   output logic            busy,
   output logic            done,
   output logic            err
);

   localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]    WLAST   = 4'(WAIT_CYC - 1);
   localparam logic [AW-1:0] TOP_V   = AW'(STACK_TOP);
   localparam logic [AW-1:0] LIMIT_V = AW'(STACK_LIMIT);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic [2:0] {OP_TEST, OP_WR, OP_RD, OP_RDAB, OP_PUSH, OP_POP} op_t;

   function automatic logic in_rng(input logic [AW-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   // addr+1 must also be in range; no wrap to address 0
   function automatic logic in_rng_ab(input logic [AW-1:0] a);
      return 32'(a) < 32'(DEPTH - 1);
   endfunction

   logic [DW-1:0]   mem [DEPTH];

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            busy_q, done_q, err_q;
   logic [DW-1:0]   rdata_q;
   logic [2*DW-1:0] rdata_ab_q;
   logic [AW-1:0]   sp_q;

   op_t             op_q;
   logic [AW-1:0]   addr_q, tad_q;
   logic [DW-1:0]   wdata_q, tdat_q;

   logic            req_any, commit;
   op_t             req_op, x_op;
   logic [AW-1:0]   x_addr, x_tad, sp_m1;
   logic [DW-1:0]   x_wdata, x_tdat;
   logic [IW-1:0]   a0, a1;

   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [DW-1:0]   wr_dat;
   logic [DW-1:0]   rdata_d;
   logic [2*DW-1:0] rdata_ab_d;
   logic [AW-1:0]   sp_d;
   logic            err_d;

   // Fixed-priority request decode
   always_comb begin
      req_any = test_en | req_wr | req_rd | req_rd_ab | req_push | req_pop;
      if (test_en)        req_op = OP_TEST;
      else if (req_wr)    req_op = OP_WR;
      else if (req_rd)    req_op = OP_RD;
      else if (req_rd_ab) req_op = OP_RDAB;
      else if (req_push)  req_op = OP_PUSH;
      else                req_op = OP_POP;
   end

   // With WAIT_CYC=0 the access completes on the accepting edge, so the
   // live inputs are used; otherwise the captured copies are.
   always_comb begin
      if (state_q == IDLE) begin
         x_op = req_op;  x_addr = addr;   x_wdata = wdata;
         x_tad = test_ad; x_tdat = test_dat;
      end else begin
         x_op = op_q;    x_addr = addr_q; x_wdata = wdata_q;
         x_tad = tad_q;  x_tdat = tdat_q;
      end
      commit = ((state_q == IDLE) && req_any && (WAIT_CYC == 0)) ||
               ((state_q == WAIT) && (cnt_q == WLAST));
   end

   // Access result, applied only on the edge entering DONE
   always_comb begin
      sp_m1      = sp_q - AW'(1);
      a0         = x_addr[IW-1:0];
      a1         = a0 + IW'(1);
      wr_en      = 1'b0;
      wr_idx     = '0;
      wr_dat     = '0;
      rdata_d    = rdata_q;
      rdata_ab_d = rdata_ab_q;
      sp_d       = sp_q;
      err_d      = 1'b0;
      case (x_op)
         OP_TEST: begin
            if (in_rng(x_tad)) begin
               wr_en = 1'b1; wr_idx = x_tad[IW-1:0]; wr_dat = x_tdat;
            end else err_d = 1'b1;
         end
         OP_WR: begin
            if (in_rng(x_addr)) begin
               wr_en = 1'b1; wr_idx = a0; wr_dat = x_wdata;
            end else err_d = 1'b1;
         end
         OP_RD: begin
            if (in_rng(x_addr)) rdata_d = mem[a0];
            else begin rdata_d = '0; err_d = 1'b1; end
         end
         OP_RDAB: begin
            if (in_rng_ab(x_addr)) rdata_ab_d = {mem[a0], mem[a1]};
            else begin rdata_ab_d = '0; err_d = 1'b1; end
         end
         OP_PUSH: begin
            if (sp_q > LIMIT_V) begin
               wr_en = 1'b1; wr_idx = sp_m1[IW-1:0]; wr_dat = x_wdata;
               sp_d  = sp_m1;
            end else err_d = 1'b1;
         end
         OP_POP: begin
            if (sp_q < TOP_V) begin
               rdata_d = mem[sp_q[IW-1:0]];
               sp_d    = sp_q + AW'(1);
            end else err_d = 1'b1;
         end
         default: err_d = 1'b1;
      endcase
   end

   // Request capture (data path, not reset)
   always_ff @(posedge clk) begin
      if (state_q == IDLE && req_any) begin
         op_q    <= req_op;
         addr_q  <= addr;
         wdata_q <= wdata;
         tad_q   <= test_ad;
         tdat_q  <= test_dat;
      end
   end

   // Storage; rst gates the commit so an access aborted in WAIT never writes
   always_ff @(posedge clk) begin
      if (!rst && commit && wr_en) mem[wr_idx] <= wr_dat;
   end

   // Control FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         rdata_ab_q <= '0;
         sp_q       <= TOP_V;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (req_any) begin
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  done_q  <= commit;
                  state_q <= commit ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (commit) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else cnt_q <= cnt_q + 4'd1;
            end
            DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         if (commit) begin
            rdata_q    <= rdata_d;
            rdata_ab_q <= rdata_ab_d;
            sp_q       <= sp_d;
            err_q      <= err_d;
         end
      end
   end

   assign rdata    = rdata_q;
   assign rdata_ab = rdata_ab_q;
   assign sp       = sp_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Testbench for mem_stack_ctrl (default parameters, WAIT_CYC=1).
module tb_mem_stack_ctrl;

   localparam int WAIT_CYC = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_rd = 1'b0, req_wr = 1'b0, req_rd_ab = 1'b0;
   logic        req_push = 1'b0, req_pop = 1'b0, test_en = 1'b0;
   logic [15:0] addr = '0, test_ad = '0;
   logic [7:0]  wdata = '0, test_dat = '0;
   logic [7:0]  rdata;
   logic [15:0] rdata_ab;
   logic [15:0] sp;
   logic        busy, done, err;

   mem_stack_ctrl #(
      .DW(8), .AW(16), .DEPTH(256), .STACK_TOP(256),
      .STACK_LIMIT(192), .WAIT_CYC(WAIT_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .req_rd(req_rd), .req_wr(req_wr), .req_rd_ab(req_rd_ab),
      .req_push(req_push), .req_pop(req_pop),
      .addr(addr), .wdata(wdata),
      .test_en(test_en), .test_ad(test_ad), .test_dat(test_dat),
      .rdata(rdata), .rdata_ab(rdata_ab), .sp(sp),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // op codes: 0 test-load, 1 wr, 2 rd, 3 rd_ab, 4 push, 5 pop, 6 wr+rd together
   typedef struct {
      int          op;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  r;
      logic [15:0] ab;
      logic [15:0] s;
      logic        e;
   } vec_t;

   typedef struct {
      logic [7:0]  r;
      logic [15:0] ab;
      logic [15:0] s;
      logic        e;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t vecs[16];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic [15:0] ab,
                               input logic [15:0] s, input logic e);
      exp_t x;
      x.r = r; x.ab = ab; x.s = s; x.e = e;
      return x;
   endfunction

   // Scoreboard: every done pulse consumes one expectation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
         end else begin
            mon_e = sbq.pop_front();
            chk("rdata", 32'(rdata), 32'(mon_e.r));
            chk("rdata_ab", 32'(rdata_ab), 32'(mon_e.ab));
            chk("sp", 32'(sp), 32'(mon_e.s));
            chk("err", 32'(err), 32'(mon_e.e));
         end
      end
   end

   task automatic clear_req();
      req_rd = 1'b0; req_wr = 1'b0; req_rd_ab = 1'b0;
      req_push = 1'b0; req_pop = 1'b0; test_en = 1'b0;
      // garbage on the data inputs: the captured request must be used
      addr = 16'hFFFF; test_ad = 16'hFFFF; wdata = 8'h00; test_dat = 8'h00;
   endtask

   task automatic drive(input int op, input logic [15:0] a, input logic [7:0] d);
      clear_req();
      case (op)
         0: begin test_en = 1'b1; test_ad = a; test_dat = d; end
         1: begin req_wr = 1'b1; addr = a; wdata = d; end
         2: begin req_rd = 1'b1; addr = a; end
         3: begin req_rd_ab = 1'b1; addr = a; end
         4: begin req_push = 1'b1; wdata = d; end
         5: begin req_pop = 1'b1; end
         6: begin req_wr = 1'b1; req_rd = 1'b1; addr = a; wdata = d; end
         default: ;
      endcase
   endtask

   // One access: drive, expect done 1+WAIT_CYC cycles after acceptance.
   // poke: pulse req_rd while the access is busy (must be ignored).
   task automatic issue(input int op, input logic [15:0] a, input logic [7:0] d,
                        input exp_t e, input bit poke);
      int lat;
      @(negedge clk);
      drive(op, a, d);
      sbq.push_back(e);
      @(posedge clk);
      #1 clear_req();
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk("busy_first", 32'(busy), 32'd1);
            if (poke) begin req_rd = 1'b1; addr = 16'h0040; end
         end
      end
      if (done !== 1'b1) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", lat, 1 + WAIT_CYC);
         sbq.delete();
      end else begin
         chk("latency", 32'(lat), 32'(1 + WAIT_CYC));
         chk("busy_at_done", 32'(busy), 32'd1);
      end
      clear_req();
      @(negedge clk);
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_pulse", 32'(done), 32'd0);
      if (poke) repeat (4) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{0, 16'h0010, 8'hA5, 8'h00, 16'h0000, 16'h0100, 1'b0};
      vecs[1]  = '{2, 16'h0010, 8'h00, 8'hA5, 16'h0000, 16'h0100, 1'b0};
      vecs[2]  = '{4, 16'h0000, 8'h11, 8'hA5, 16'h0000, 16'h00FF, 1'b0};
      vecs[3]  = '{4, 16'h0000, 8'h22, 8'hA5, 16'h0000, 16'h00FE, 1'b0};
      vecs[4]  = '{5, 16'h0000, 8'h00, 8'h22, 16'h0000, 16'h00FF, 1'b0};
      vecs[5]  = '{5, 16'h0000, 8'h00, 8'h11, 16'h0000, 16'h0100, 1'b0};
      vecs[6]  = '{5, 16'h0000, 8'h00, 8'h11, 16'h0000, 16'h0100, 1'b1};
      vecs[7]  = '{1, 16'h0020, 8'h34, 8'h11, 16'h0000, 16'h0100, 1'b0};
      vecs[8]  = '{1, 16'h0021, 8'h12, 8'h11, 16'h0000, 16'h0100, 1'b0};
      vecs[9]  = '{3, 16'h0020, 8'h00, 8'h11, 16'h3412, 16'h0100, 1'b0};
      vecs[10] = '{3, 16'h00FF, 8'h00, 8'h11, 16'h0000, 16'h0100, 1'b1};
      vecs[11] = '{2, 16'h0300, 8'h00, 8'h00, 16'h0000, 16'h0100, 1'b1};
      vecs[12] = '{1, 16'h0100, 8'h99, 8'h00, 16'h0000, 16'h0100, 1'b1};
      vecs[13] = '{0, 16'h0100, 8'h99, 8'h00, 16'h0000, 16'h0100, 1'b1};
      vecs[14] = '{2, 16'h00FF, 8'h00, 8'h11, 16'h0000, 16'h0100, 1'b0};
      vecs[15] = '{3, 16'h00FE, 8'h00, 8'h11, 16'h2211, 16'h0100, 1'b0};

      // request held during reset is never sampled
      req_rd = 1'b1; addr = 16'h0010;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_req();
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_rdata_ab", 32'(rdata_ab), 32'h0);
      chk("rst_sp", 32'(sp), 32'h100);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      for (int i = 0; i < 16; i++)
         issue(vecs[i].op, vecs[i].a, vecs[i].d,
               mk(vecs[i].r, vecs[i].ab, vecs[i].s, vecs[i].e), 1'b0);

      // fill the stack down to STACK_LIMIT, then overflow
      for (int i = 0; i < 64; i++)
         issue(4, 16'h0, 8'(i), mk(8'h11, 16'h2211, 16'(255 - i), 1'b0), 1'b0);
      issue(4, 16'h0, 8'hEE, mk(8'h11, 16'h2211, 16'd192, 1'b1), 1'b0);
      issue(5, 16'h0, 8'h00, mk(8'h3F, 16'h2211, 16'd193, 1'b0), 1'b0);

      // wr beats rd; a rd pulsed while busy is dropped
      issue(6, 16'h0040, 8'h5A, mk(8'h3F, 16'h2211, 16'd193, 1'b0), 1'b1);
      issue(2, 16'h0040, 8'h00, mk(8'h5A, 16'h2211, 16'd193, 1'b0), 1'b0);
      issue(0, 16'h0030, 8'hC3, mk(8'h5A, 16'h2211, 16'd193, 1'b0), 1'b0);

      // rst in WAIT aborts the write
      @(negedge clk);
      drive(1, 16'h0030, 8'h77);
      @(posedge clk);
      #1 clear_req();
      @(negedge clk);
      chk("abort_busy_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sp", 32'(sp), 32'h100);
      chk("abort_rdata", 32'(rdata), 32'h0);
      chk("abort_rdata_ab", 32'(rdata_ab), 32'h0);
      repeat (3) @(negedge clk);
      issue(2, 16'h0030, 8'h00, mk(8'hC3, 16'h0000, 16'h0100, 1'b0), 1'b0);

      // rst in DONE keeps the committed write, outputs still reset
      @(negedge clk);
      drive(1, 16'h0031, 8'h9C);
      sbq.push_back(mk(8'hC3, 16'h0000, 16'h0100, 1'b0));
      @(posedge clk);
      #1 clear_req();
      @(negedge clk);
      @(negedge clk);
      chk("done_before_rst", 32'(done), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_done_rdata", 32'(rdata), 32'h0);
      chk("rst_done_busy", 32'(busy), 32'd0);
      chk("rst_done_done", 32'(done), 32'd0);
      issue(2, 16'h0031, 8'h00, mk(8'h9C, 16'h0000, 16'h0100, 1'b0), 1'b0);
      issue(3, 16'h0030, 8'h00, mk(8'h9C, 16'hC39C, 16'h0100, 1'b0), 1'b0);

      // request high only while rst is asserted
      @(negedge clk);
      rst = 1'b1; req_pop = 1'b1; req_wr = 1'b1; addr = 16'h0031; wdata = 8'h01;
      @(posedge clk);
      #1 rst = 1'b0;
      clear_req();
      repeat (4) @(negedge clk);
      chk("rst_req_busy", 32'(busy), 32'd0);
      chk("rst_req_sp", 32'(sp), 32'h100);
      issue(2, 16'h0031, 8'h00, mk(8'h9C, 16'h0000, 16'h0100, 1'b0), 1'b0);

      chk("queue_empty", 32'(sbq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stack_ctrl.md
MEM_STACK_CTRL -- requirements
Module: mem_stack_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DW, 8, data word width.
- AW, 16, address and SP width.
- DEPTH, 256, memory words; legal addresses 0..DEPTH-1.
- STACK_TOP, 256, SP value when the stack is empty.
- STACK_LIMIT, 192, lowest SP value a push may reach.
- WAIT_CYC, 1, extra wait cycles per access (0..15).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- req_rd, in, 1, single-word read at addr.
- req_wr, in, 1, write wdata to addr.
- req_rd_ab, in, 1, double-word read of addr and addr+1.
- req_push, in, 1, push wdata onto the stack.
- req_pop, in, 1, pop the stack into rdata.
- addr, in, AW, access address.
- wdata, in, DW, write or push data.
- test_en, in, 1, test-load strobe.
- test_ad, in, AW, test-load address.
- test_dat, in, DW, test-load data.
- rdata, out, DW, read or pop result.
- rdata_ab, out, 2*DW, double read result {mem[addr], mem[addr+1]}.
- sp, out, AW, current stack pointer.
- busy, out, 1, access in progress.
- done, out, 1, one-cycle completion pulse.
- err, out, 1, error status of the last completed access.
REQ-003 The block SHALL be clocked by clk only, with synchronous active-high reset rst.

Function
REQ-004 Storage SHALL be an internal array of DEPTH words of DW bits; rst SHALL NOT clear it.
REQ-005 The FSM SHALL have states IDLE, WAIT and DONE.
- IDLE -> WAIT when a request is accepted and WAIT_CYC>0.
- IDLE -> DONE when a request is accepted and WAIT_CYC=0.
- WAIT -> DONE after WAIT_CYC cycles in WAIT.
- DONE -> IDLE unconditionally.
REQ-006 Requests SHALL be sampled only in IDLE; requests asserted in WAIT or DONE SHALL be ignored, not queued.
REQ-007 Simultaneous requests in IDLE SHALL be resolved by fixed priority test_en > req_wr > req_rd > req_rd_ab > req_push > req_pop; the losers SHALL be dropped.
REQ-008 Timing: for a request sampled at edge T, busy SHALL be high for cycles T+1 through T+1+WAIT_CYC; done SHALL pulse high for exactly the cycle T+1+WAIT_CYC.
REQ-009 The request SHALL be captured at T: opcode, addr, wdata, test_ad and test_dat; later changes on those inputs SHALL have no effect.
REQ-010 Writes, pushes and test-loads SHALL commit on the edge entering DONE. Their data SHALL be visible to any request accepted after done.
REQ-011 rdata and rdata_ab SHALL update on the edge entering DONE and hold until the next completion of the same kind.
REQ-012 Push: if sp > STACK_LIMIT, then mem[sp-1] <= wdata and sp <= sp-1. Otherwise the push is an overflow: err=1, with no write and no change to sp.
REQ-013 Pop: if sp < STACK_TOP, then rdata <= mem[sp] and sp <= sp+1. Otherwise the pop is an underflow: err=1, with rdata and sp unchanged.
REQ-014 An addr or test_ad >= DEPTH SHALL complete with err=1 and no write. For rd, rdata SHALL be 0.
REQ-015 rd_ab with addr >= DEPTH-1 SHALL complete with err=1 and rdata_ab=0; addresses SHALL NOT wrap.
REQ-016 err SHALL update on the edge entering DONE: 1 for a failed access, 0 for a successful one. It SHALL hold until the next done.
REQ-017 sp SHALL change only on a successful push or pop, at the edge entering DONE.

Reset
REQ-018 While rst=1 at an edge, the block SHALL set: state=IDLE, rdata=0, rdata_ab=0, sp=STACK_TOP, busy=0, done=0, err=0.
REQ-019 rst asserted in WAIT SHALL abort the access: no memory write, no sp change, no done pulse.
REQ-020 rst asserted in DONE SHALL leave an already committed write in memory. Outputs SHALL still take their reset values.
REQ-021 A request held high during the rst cycle SHALL be ignored; sampling SHALL start at the first edge with rst=0.

Verification (defaults, WAIT_CYC=1)
REQ-022 The bench SHALL cover at least these directed scenarios:
- test_en with test_ad=0x0010, test_dat=0xA5, then req_rd addr=0x0010 -> done 2 cycles after acceptance, rdata=0xA5, err=0.
- req_push wdata=0x11, then 0x22, then two req_pop -> sp goes 256, 255, 254, 255, 256; rdata 0x22 then 0x11.
- A 3rd req_pop at sp=256 -> err=1, sp=256, rdata holds 0x11; 64 pushes succeed (sp=192), the 65th -> err=1, sp=192.
- Write 0x34 to 0x0020 and 0x12 to 0x0021, then req_rd_ab addr=0x0020 -> rdata_ab=0x3412. Then req_rd_ab addr=0x00FF -> err=1, rdata_ab=0.
- req_wr and req_rd asserted together in IDLE -> write only, one done; req_rd pulsed while busy -> ignored, no second done.
- req_wr addr=0x0030 wdata=0x77, rst in the WAIT cycle -> no done, mem[0x30] unchanged, sp=256; rd 0x0300 -> err=1, rdata=0.
